// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// The receiver drives the held byte and status flags; the consumer returns data_read.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       full;
  logic       frame_error;
  logic       overrun;
  logic       parity_error;
  logic       data_read;

  modport master (
    output data_out, full, frame_error, overrun, parity_error,
    input  data_read
  );

  modport slave (
    input  data_out, full, frame_error, overrun, parity_error,
    output data_read
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rxd,
  uart_rx_if.master bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_CYCLES / 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  function automatic logic parity_err(input logic [7:0] b, input logic p);
    return (^b) != p;
  endfunction

  logic             rx_p0, rx_p1, rx_prev;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic             shift_en, par_en;
  logic             done_p2, done_nx;
  logic             stop_bit, stop_nx;
  logic [7:0]       shift;

  // Stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rxd;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      done_p2  <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      done_p2  <= done_nx;
      stop_bit <= stop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shift_en = 1'b0;
    par_en   = 1'b0;
    done_nx  = 1'b0;
    stop_nx  = stop_bit;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rx_prev && !rx_p1) state_nx = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          shift_en = 1'b1;
          idx_nx   = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          par_en   = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          done_nx  = 1'b1;
          stop_nx  = rx_p1;
          // A low stop bit parks in BREAK so a held-low line is not read as 0x00 bytes
          state_nx = rx_p1 ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_nx = '0;
        if (rx_p1) state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift <= {rx_p1, shift[7:1]};
  end

  // Stage p2: holding register and handshake flags, loaded one cycle after the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out    <= 8'h00;
      bus.full        <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
    end else if (done_p2) begin
      bus.data_out    <= shift;
      bus.full        <= 1'b1;
      bus.frame_error <= ~stop_bit;
      bus.overrun     <= bus.full & ~bus.data_read;
    end else if (bus.full && bus.data_read) begin
      bus.full        <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (par_en) par_bit <= rx_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.parity_error <= 1'b0;
    else if (done_p2)
      bus.parity_error <= parity_err(shift, par_bit);
    else if (bus.full && bus.data_read)
      bus.parity_error <= 1'b0;
  end
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: loopback bytes, glitch, frame error, overrun, reset mid-frame.
// Line rate scaled to 32 clocks per bit to keep runs short.
module tb_uart_rx;
  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic wait_full(input string tag);
    for (int i = 0; i < 4 * BC && !bus.full; i++) @(negedge clk);
    chk(tag, bus.full, 1'b1);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
  endtask

  logic seen;

  initial begin
    rst_n         = 1'b0;
    rxd           = 1'b1;
    bus.data_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_fe",   bus.frame_error, 1'b0);
    chk("rst_ov",   bus.overrun, 1'b0);
    chk("rst_pe",   bus.parity_error, 1'b0);
    rst_n = 1'b1;
    repeat (BC) @(negedge clk);

    // loopback pair
    send_frame(8'hAA, 1'b1);
    wait_full("aa_full");
    chk("aa_data", bus.data_out, 8'hAA);
    chk("aa_fe",   bus.frame_error, 1'b0);
    chk("aa_ov",   bus.overrun, 1'b0);
    pulse_read();
    chk("aa_clr",  bus.full, 1'b0);
    chk("aa_hold", bus.data_out, 8'hAA);
    send_frame(8'hBB, 1'b1);
    wait_full("bb_full");
    chk("bb_data", bus.data_out, 8'hBB);
    chk("bb_fe",   bus.frame_error, 1'b0);
    chk("bb_ov",   bus.overrun, 1'b0);
    pulse_read();
    chk("bb_clr",  bus.full, 1'b0);

    // short low glitch must not start a frame
    seen = 1'b0;
    rxd  = 1'b0;
    repeat (BC / 4) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 2 * BC; i++) begin
      @(negedge clk);
      if (bus.full) seen = 1'b1;
    end
    chk("glitch_full", seen, 1'b0);
    send_frame(8'h5A, 1'b1);
    wait_full("5a_full");
    chk("5a_data", bus.data_out, 8'h5A);
    pulse_read();

    // frame error followed by a held-low line
    send_frame(8'h55, 1'b0);
    repeat (150) @(negedge clk);
    chk("fe_full", bus.full, 1'b1);
    chk("fe_data", bus.data_out, 8'h55);
    chk("fe_flag", bus.frame_error, 1'b1);
    pulse_read();
    chk("fe_clr",  bus.frame_error, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.full) seen = 1'b1;
    end
    chk("brk_none", seen, 1'b0);
    rxd = 1'b1;
    repeat (2 * BC) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    wait_full("3c_full");
    chk("3c_data", bus.data_out, 8'h3C);
    chk("3c_fe",   bus.frame_error, 1'b0);
    pulse_read();

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_full("ov_full");
    chk("ov_data", bus.data_out, 8'h22);
    chk("ov_flag", bus.overrun, 1'b1);
    pulse_read();
    chk("ov_full_clr", bus.full, 1'b0);
    chk("ov_flag_clr", bus.overrun, 1'b0);

    // reset during bit 4 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    repeat (BC / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_data", bus.data_out, 8'h00);
    chk("mr_full", bus.full, 1'b0);
    chk("mr_fe",   bus.frame_error, 1'b0);
    chk("mr_ov",   bus.overrun, 1'b0);
    chk("mr_pe",   bus.parity_error, 1'b0);
    rst_n = 1'b1;
    repeat (BC / 2 + 4 * BC) @(negedge clk);
    chk("mr_none", bus.full, 1'b0);
    send_frame(8'h0F, 1'b1);
    wait_full("0f_full");
    chk("0f_data", bus.data_out, 8'h0F);
    chk("0f_fe",   bus.frame_error, 1'b0);
    chk("0f_ov",   bus.overrun, 1'b0);
    pulse_read();

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so even parity needs a 1
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_full("p1_full");
    chk("p1_data", bus.data_out, 8'h07);
    chk("p1_pe",   bus.parity_error, 1'b0);
    pulse_read();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_full("p0_full");
    chk("p0_data", bus.data_out, 8'h07);
    chk("p0_pe",   bus.parity_error, 1'b1);
    pulse_read();
    chk("p0_clr",  bus.parity_error, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the TXD line produced by uart_tx.
- Rebuilds 8-bit bytes and presents them on a valid/acknowledge handshake to a downstream consumer, either a future dma_rx or the bench.
- Closes the loopback path dma_tx -> uart_tx -> uart_rx, so transmitted memory contents can be checked on the receive side.
- Frame format: 8N1 (start bit, 8 data bits LSB first, 1 stop bit), with an optional parity bit.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BIT_CYCLES = CLK_FREQ/BAUD, integer-truncated; 868 at the defaults.

Ports:
- Clk  input  1  system clock; all logic on its rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- RXD  input  1  serial line; idles high; asynchronous to Clk.
- Data_read  input  1  one-cycle pulse from the consumer; acknowledges the held byte.
- Data_out  output  8  last received byte.
- Full  output  1  high while Data_out holds an unacknowledged byte.
- Frame_error  output  1  stop bit of the held byte was sampled 0.
- Overrun  output  1  sticky; a new byte overwrote an unacknowledged one.
- Parity_error  output  1  parity mismatch on the held byte; tied 0 when the optional feature is absent.

Behaviour:
- Reset: Data_out=0x00, Full=0, Frame_error=0, Overrun=0, Parity_error=0, state IDLE, all counters 0. The RXD synchronizer resets to 1.
- Synchronizer: RXD passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Bit-period counter: counts 0..BIT_CYCLES-1; width $clog2(BIT_CYCLES).
- IDLE: a 1->0 transition on rx_s loads the counter and goes to START.
- START: at count BIT_CYCLES/2, rx_s is sampled.
  - 1: glitch; return to IDLE, nothing reported.
  - 0: reset the counter, bit index=0, go to DATA.
- DATA: each sample taken after a full BIT_CYCLES (mid-bit) is shifted in LSB first.
  - After index 7: go to PARITY if the feature is compiled in, else to STOP.
- STOP: sample at mid-bit, then update outputs on the next cycle:
  - Data_out=assembled byte; Full=1.
  - Frame_error=~stop_sample; Parity_error=result of the parity check.
  - Next state: IDLE if stop_sample=1, else BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line being decoded as 0x00 bytes.
- Latency: Full rises 2 synchronizer cycles + 1 cycle after the stop-bit mid-sample, i.e. about 9.5 bit periods after the start edge.
- Data_read while Full=1: Full, Frame_error, Parity_error and Overrun clear on the next cycle. Data_out holds its value.
- Data_read while Full=0: ignored.
- Byte completes while Full=1 and Data_read=0: Data_out is overwritten, Overrun=1. Overrun stays set until a Data_read.
- Byte completes in the same cycle as Data_read: the new byte is loaded, Full stays 1, Overrun=0, error flags are taken from the new byte.
- Rst_n low mid-frame: immediate return to reset values. After release, the receiver waits for a fresh 1->0 edge; a frame that was already running is not resynchronized mid-frame.
- Frame error or parity error: the byte is still delivered. The flags describe the held byte.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one extra bit at mid-bit.
  - Even parity: Parity_error=1 when (^byte) != parity_bit.
  - Frame length is 11 bits.
- Undefined:
  - DATA goes directly to STOP.
  - Parity_error is tied 0.
  - Frame length is 10 bits.

Test Plan:
- Loopback: uart_tx sends 0xAA then 0xBB, with Data_read pulsed after each Full -> Data_out=0xAA then 0xBB; Frame_error=0 and Overrun=0 throughout.
- Glitch: RXD driven low for 200 cycles then high (BIT_CYCLES=868) -> no state leaves IDLE; Full stays 0.
- Frame error: 0x55 driven with the stop bit forced 0, line held low for 3000 cycles, then a normal 0x3C -> first Full has Data_out=0x55 and Frame_error=1. No extra byte during the low period. Second byte is 0x3C with Frame_error=0.
- Overrun: 0x11 then 0x22 sent back to back with no Data_read -> Data_out=0x22, Full=1, Overrun=1. One Data_read pulse -> Full=0, Overrun=0.
- Reset mid-frame: Rst_n pulsed low during bit 4 of 0xF0, then 0x0F sent -> all outputs at reset values during reset; next Full has Data_out=0x0F.
- Parity (UART_RX_PARITY_EN): 0x07 sent with parity bit 1 -> Parity_error=0; 0x07 sent with parity bit 0 -> Parity_error=1.
